systolic_drain: RTL and testbench

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

---
 rtl/systolic_drain.sv | 223 ++++++++++++++++++++++
 tb/tb_systolic_drain.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// ---------------------------------------------------------------------------
// systolic_drain
//
// Purpose:
//   Collects the skewed bottom-row results of a systolic array and turns them
//   into aligned rows.  Column c of a row arrives c*COL_SKEW cycles after
//   column 0, so each column gets a delay line of (COLS-1-c)*COL_SKEW
//   enabled cycles and the row valid gets (COLS-1)*COL_SKEW.  Aligned rows
//   are written into a small FIFO that the consumer drains with a
//   valid/ready handshake.  Each stored row carries a "last row of tile" flag.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   enable     advances the deskew pipeline; low freezes it (no FIFO write)
//   in_valid   column 0 result valid this cycle
//   in_sum     COLS packed result words, column c at [c*DATA_SIZE +: DATA_SIZE]
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head row
//   out_row    head aligned row (0 when empty), same packing as in_sum
//   out_last   head row is the last row of a tile (gated by out_valid)
//   overflow   sticky flag: an aligned row was dropped because the FIFO was full
//
// Configuration macro:
//   SYSTOLIC_DRAIN_RELU_EN  when defined, negative (two's complement) column
//                           words are replaced by 0 as the row is written.
// ---------------------------------------------------------------------------
module systolic_drain #(
    parameter int DATA_SIZE     = 32,
    parameter int COLS          = 4,
    parameter int COL_SKEW      = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int ROWS_PER_TILE = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      in_valid,
    input  logic [COLS*DATA_SIZE-1:0] in_sum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*DATA_SIZE-1:0] out_row,
    output logic                      out_last,
    output logic                      overflow
);

    localparam int ROW_W  = COLS * DATA_SIZE;
    localparam int VLAT   = (COLS - 1) * COL_SKEW;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int TILE_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

    logic [ROW_W-1:0] aligned_row;
    logic             aligned_valid;
    logic [ROW_W-1:0] wr_row;

    // -----------------------------------------------------------------------
    // Valid delay line.  The last stage is consumed directly by the FIFO
    // write, so a row started at edge t is written at edge t+VLAT.
    // -----------------------------------------------------------------------
    if (VLAT == 0) begin : g_vpass
        assign aligned_valid = in_valid;
    end else begin : g_vdly
        logic [VLAT-1:0] vld_q;
        logic [VLAT-1:0] vld_d;

        always_comb begin
            vld_d = vld_q;
            if (enable) begin
                vld_d[0] = in_valid;
                for (int i = 1; i < VLAT; i++) begin
                    vld_d[i] = vld_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign aligned_valid = vld_q[VLAT-1];
    end

    // -----------------------------------------------------------------------
    // Per-column data delay lines.  The last column has zero delay: it is
    // taken straight from in_sum on the write edge.
    // -----------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = (COLS - 1 - c) * COL_SKEW;

        if (D == 0) begin : g_pass
            assign aligned_row[c*DATA_SIZE +: DATA_SIZE] = in_sum[c*DATA_SIZE +: DATA_SIZE];
        end else begin : g_dly
            logic [DATA_SIZE-1:0] dly_q [D];
            logic [DATA_SIZE-1:0] dly_d [D];

            always_comb begin
                dly_d = dly_q;
                if (enable) begin
                    dly_d[0] = in_sum[c*DATA_SIZE +: DATA_SIZE];
                    for (int i = 1; i < D; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dly_q <= '{default: '0};
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign aligned_row[c*DATA_SIZE +: DATA_SIZE] = dly_q[D-1];
        end
    end

    // -----------------------------------------------------------------------
    // Row post-processing applied at FIFO write time.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_row = aligned_row;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        for (int c = 0; c < COLS; c++) begin
            if (aligned_row[c*DATA_SIZE + DATA_SIZE - 1]) begin
                wr_row[c*DATA_SIZE +: DATA_SIZE] = '0;
            end
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Aligned-row FIFO with tile framing.
    // -----------------------------------------------------------------------
    logic [ROW_W-1:0]      mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0]      mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q;
    logic [FIFO_DEPTH-1:0] last_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TILE_W-1:0]     tile_q, tile_d;
    logic                  overflow_q, overflow_d;

    logic push_req;
    logic push_ok;
    logic pop;
    logic full;

    assign push_req = enable & aligned_valid;
    assign pop      = (count_q != '0) & out_ready;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req & (~full | pop);

    // Next-state for storage, pointers, count, tile counter and overflow.
    always_comb begin
        mem_d      = mem_q;
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tile_d     = tile_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            mem_d[wr_ptr_q]  = wr_row;
            last_d[wr_ptr_q] = (tile_q == TILE_W'(ROWS_PER_TILE - 1));
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            if (tile_q == TILE_W'(ROWS_PER_TILE - 1)) begin
                tile_d = '0;
            end else begin
                tile_d = tile_q + TILE_W'(1);
            end
        end else if (push_req) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; reset has priority over every other action.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tile_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tile_q     <= tile_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: every read is gated by the count.
    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        last_q <= last_d;
    end

    assign out_valid = (count_q != '0);
    assign out_row   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_last  = out_valid & last_q[rd_ptr_q];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_systolic_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_drain
//
// Directed bench for systolic_drain with COLS=4, COL_SKEW=3, FIFO_DEPTH=4,
// ROWS_PER_TILE=4.  A small driver model presents each scheduled row with the
// array's skew: on the n-th enabled cycle column c carries the row that was
// started on enabled cycle n-c*COL_SKEW, and filler words otherwise.
// ---------------------------------------------------------------------------
module tb_systolic_drain;

    localparam int DS  = 32;
    localparam int NC  = 4;
    localparam int SK  = 3;
    localparam int FD  = 4;
    localparam int RPT = 4;
    localparam int RW  = NC * DS;
    localparam int LAT = (NC - 1) * SK;

`ifdef SYSTOLIC_DRAIN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          in_valid = 1'b0;
    logic [RW-1:0] in_sum = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          overflow;

    always #5 clk = ~clk;

    systolic_drain #(
        .DATA_SIZE    (DS),
        .COLS         (NC),
        .COL_SKEW     (SK),
        .FIFO_DEPTH   (FD),
        .ROWS_PER_TILE(RPT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_sum   (in_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_last (out_last),
        .overflow (overflow)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    bit            start_v [0:2047];
    logic [RW-1:0] row_d   [0:2047];

    typedef struct {
        logic [RW-1:0] cols;
        logic [RW-1:0] exp_row;
        bit            exp_last;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [RW-1:0] mk_row(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic schedule_row(input int at, input logic [RW-1:0] data);
        start_v[at] = 1'b1;
        row_d[at]   = data;
    endtask

    // Drives one clock cycle; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input bit en, input bit rdy, input bit rst);
        @(negedge clk);
        reset     = rst;
        enable    = en;
        out_ready = rdy;
        if (en) begin
            in_valid = start_v[n];
            for (int c = 0; c < NC; c++) begin
                int k;
                k = n - c * SK;
                if (k >= 0 && start_v[k]) begin
                    in_sum[c*DS +: DS] = row_d[k][c*DS +: DS];
                end else begin
                    in_sum[c*DS +: DS] = 32'hDEAD_0000 | 32'(c);
                end
            end
        end else begin
            in_valid = 1'b1;
            in_sum   = {NC{32'hBAD0_BAD0}};
        end
        @(posedge clk);
        if (en && !rst) n++;
        #1;
    endtask

    task automatic do_reset();
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            start_v[i] = 1'b0;
            row_d[i]   = '0;
        end

        vecs[0].cols     = {32'h13, 32'h12, 32'h11, 32'h10};
        vecs[0].exp_row  = {32'h13, 32'h12, 32'h11, 32'h10};
        vecs[0].exp_last = 1'b0;
        vecs[1].cols     = {32'h7FFF_FFFF, 32'h0000_0001, 32'h1234_5678, 32'h0000_ABCD};
        vecs[1].exp_row  = {32'h7FFF_FFFF, 32'h0000_0001, 32'h1234_5678, 32'h0000_ABCD};
        vecs[1].exp_last = 1'b0;
        vecs[2].cols     = {32'h00C0_FFEE, 32'h5A5A_5A5A, 32'h0F0F_0F0F, 32'h3C3C_3C3C};
        vecs[2].exp_row  = {32'h00C0_FFEE, 32'h5A5A_5A5A, 32'h0F0F_0F0F, 32'h3C3C_3C3C};
        vecs[2].exp_last = 1'b0;
        vecs[3].cols     = {32'h33, 32'h22, 32'h11, 32'hFFFF_FFFF};
        vecs[3].exp_row  = RELU ? {32'h33, 32'h22, 32'h11, 32'h0}
                                : {32'h33, 32'h22, 32'h11, 32'hFFFF_FFFF};
        vecs[3].exp_last = 1'b1;
        vecs[4].cols     = {32'h44, 32'h8000_0000, 32'h66, 32'h77};
        vecs[4].exp_row  = RELU ? {32'h44, 32'h0, 32'h66, 32'h77}
                                : {32'h44, 32'h8000_0000, 32'h66, 32'h77};
        vecs[4].exp_last = 1'b0;

        // Reset state.
        do_reset();
        applyStimulus(0, 0, 0);
        checkFlag("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_row", out_row, '0);
        checkFlag("reset_out_last", out_last, 1'b0);
        checkFlag("reset_overflow", overflow, 1'b0);

        // Single rows from the table: write lands exactly LAT edges after start.
        for (int v = 0; v < 5; v++) begin
            schedule_row(n, vecs[v].cols);
            repeat (LAT) applyStimulus(1, 0, 0);
            checkFlag($sformatf("vec%0d_not_early", v), out_valid, 1'b0);
            applyStimulus(1, 0, 0);
            checkFlag($sformatf("vec%0d_valid", v), out_valid, 1'b1);
            checkOutput($sformatf("vec%0d_row", v), out_row, vecs[v].exp_row);
            checkFlag($sformatf("vec%0d_last", v), out_last, vecs[v].exp_last);
            applyStimulus(1, 1, 0);
            checkFlag($sformatf("vec%0d_popped", v), out_valid, 1'b0);
        end

        // Two stall cycles mid-row push the write from edge 9 to edge 11.
        do_reset();
        schedule_row(n, mk_row(32'h20));
        repeat (5) applyStimulus(1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0);
        repeat (4) applyStimulus(1, 0, 0);
        checkFlag("stall_not_early", out_valid, 1'b0);
        applyStimulus(1, 0, 0);
        checkFlag("stall_valid", out_valid, 1'b1);
        checkOutput("stall_row", out_row, mk_row(32'h20));
        applyStimulus(1, 1, 0);

        // Five back-to-back rows, consumer stalled: fifth row is dropped.
        do_reset();
        for (int r = 0; r < 5; r++) schedule_row(n + r, mk_row(32'h300 + 32'(r) * 32'h10));
        repeat (LAT + 4) applyStimulus(1, 0, 0);
        checkFlag("ovf_before_fifth", overflow, 1'b0);
        applyStimulus(1, 0, 0);
        checkFlag("ovf_after_fifth", overflow, 1'b1);
        for (int r = 0; r < 4; r++) begin
            checkFlag($sformatf("ovf_valid%0d", r), out_valid, 1'b1);
            checkOutput($sformatf("ovf_row%0d", r), out_row, mk_row(32'h300 + 32'(r) * 32'h10));
            checkFlag($sformatf("ovf_last%0d", r), out_last, r == 3);
            applyStimulus(1, 1, 0);
        end
        checkFlag("ovf_drained", out_valid, 1'b0);
        checkFlag("ovf_sticky", overflow, 1'b1);

        // Full FIFO with a pop on the push edge: row accepted, no overflow.
        do_reset();
        for (int r = 0; r < 5; r++) schedule_row(n + r, mk_row(32'h400 + 32'(r) * 32'h10));
        repeat (LAT + 4) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkFlag("fullpop_overflow", overflow, 1'b0);
        for (int r = 1; r < 5; r++) begin
            checkOutput($sformatf("fullpop_row%0d", r), out_row, mk_row(32'h400 + 32'(r) * 32'h10));
            applyStimulus(1, 1, 0);
        end
        checkFlag("fullpop_drained", out_valid, 1'b0);

        // Tile framing over 8 rows, drained as they arrive.
        do_reset();
        for (int r = 0; r < 8; r++) schedule_row(n + r, mk_row(32'h600 + 32'(r) * 32'h10));
        repeat (LAT) applyStimulus(1, 1, 0);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(1, 1, 0);
            checkOutput($sformatf("tile_row%0d", r), out_row, mk_row(32'h600 + 32'(r) * 32'h10));
            checkFlag($sformatf("tile_last%0d", r), out_last, (r == 3) || (r == 7));
        end
        applyStimulus(1, 1, 0);
        checkFlag("tile_drained", out_valid, 1'b0);

        // Reset mid-row with a full FIFO and overflow set: everything clears.
        do_reset();
        for (int r = 0; r < 5; r++) schedule_row(n + r, mk_row(32'h700 + 32'(r) * 32'h10));
        repeat (LAT + 5) applyStimulus(1, 0, 0);
        checkFlag("pre_reset_overflow", overflow, 1'b1);
        schedule_row(n, mk_row(32'h500));
        repeat (5) applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        checkFlag("midreset_out_valid", out_valid, 1'b0);
        checkOutput("midreset_out_row", out_row, '0);
        checkFlag("midreset_out_last", out_last, 1'b0);
        checkFlag("midreset_overflow", overflow, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 0);
            checkFlag($sformatf("midreset_no_write%0d", i), out_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
